tow_round_ctrl: RTL and testbench

//   Parametrised N-player reaction-round controller for the tug-of-war game; successor to the fixed 2-player MC/pb_latch/scorer chain.

---
 rtl/tow_round_ctrl_pkg.sv | 24 ++
 rtl/tow_round_ctrl_if.sv | 35 +++
 rtl/tow_round_ctrl_press_arbiter.sv | 42 ++++
 rtl/tow_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tow_round_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/tow_round_ctrl_pkg.sv
// Shared state codes and width helpers for the tug-of-war round controller.
// LED and VGA decoders read state_o against tow_state_e.
package tow_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GO     = 3'd3,
        ST_RESULT = 3'd4,
        ST_OVER   = 3'd5
    } tow_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tow_round_ctrl_if.sv
// Player/game-side signal bundle of the round controller.
// master drives buttons, tick, random and start; slave is the controller.
interface tow_round_ctrl_if
    import tow_round_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8,
    parameter int DELAY_W     = 8
);
    localparam int ID_W = id_width(NUM_PLAYERS);

    logic                           tick;
    logic [DELAY_W-1:0]             rand_in;
    logic [NUM_PLAYERS-1:0]         btn;
    logic                           start;
    logic                           leds_on;
    logic                           winner_valid;
    logic [ID_W-1:0]                winner_id;
    logic                           tie;
    logic                           false_start;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic                           match_over;
    logic [2:0]                     state_o;

    modport master (
        output tick, rand_in, btn, start,
        input  leds_on, winner_valid, winner_id, tie, false_start, scores, match_over, state_o
    );

    modport slave (
        input  tick, rand_in, btn, start,
        output leds_on, winner_valid, winner_id, tie, false_start, scores, match_over, state_o
    );

endinterface

// File: rtl/tow_round_ctrl_press_arbiter.sv
// Rising-edge press detector and first-press arbiter for the player buttons.
// Only btn_q is stored; everything else is valid in the same cycle as btn.
module tow_round_ctrl_press_arbiter
    import tow_round_ctrl_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    localparam int ID_W        = id_width(NUM_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] btn,
    output logic [NUM_PLAYERS-1:0] press,
    output logic                   one_hot,
    output logic                   multi,
    output logic [ID_W-1:0]        id
);

    logic [NUM_PLAYERS-1:0] btn_q;
    logic [NUM_PLAYERS-1:0] btn_d;

    always_comb btn_d = btn;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_d;
        end
    end

    always_comb begin
        press   = btn & ~btn_q;
        one_hot = (press != '0) && ((press & (press - NUM_PLAYERS'(1))) == '0);
        multi   = (press != '0) && !one_hot;
        id      = '0;
        // Scan downward so the lowest pressed index is the one left in id.
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (press[p]) id = ID_W'(p);
        end
    end

endmodule

// File: rtl/tow_round_ctrl.sv
// N-player reaction-round controller: arms a round, waits a random delay,
// arbitrates the first press, penalises false starts and keeps the scores.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   ARM    | waiting for all buttons released, then draws the delay
//   WAIT   | random delay running; any press is a false start
//   GO     | leds lit, first press wins, timeout voids the round
//   RESULT | display hold, presses ignored
//   OVER   | someone reached WIN_SCORE, scores frozen until start
module tow_round_ctrl
    import tow_round_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int SCORE_W       = 8,
    parameter int DELAY_W       = 8,
    parameter int MIN_DELAY     = 16,
    parameter int TIMEOUT_TICKS = 255,
    parameter int HOLD_TICKS    = 64,
    parameter int WIN_SCORE     = 7
) (
    input  logic             clk,
    input  logic             rst,
    tow_round_ctrl_if.slave  bus
);

    localparam int ID_W  = id_width(NUM_PLAYERS);
    localparam int CNT_W = max3(DELAY_W + 1, $clog2(TIMEOUT_TICKS + 1), $clog2(HOLD_TICKS + 1));

    localparam logic [CNT_W-1:0]   MIN_C     = CNT_W'(MIN_DELAY);
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0]   HOLD_C    = CNT_W'(HOLD_TICKS);
    localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_SCORE);

    logic [NUM_PLAYERS-1:0] press;
    logic                   one_hot;
    logic                   multi;
    logic [ID_W-1:0]        press_id;

    tow_round_ctrl_press_arbiter #(.NUM_PLAYERS(NUM_PLAYERS)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .btn     (bus.btn),
        .press   (press),
        .one_hot (one_hot),
        .multi   (multi),
        .id      (press_id)
    );

    tow_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
    logic               leds_on_q, leds_on_d;
    logic               winner_valid_q, winner_valid_d;
    logic [ID_W-1:0]    winner_id_q, winner_id_d;
    logic               tie_q, tie_d;
    logic               false_start_q, false_start_d;
    logic               match_over_q, match_over_d;
    logic               any_win;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        score_d        = score_q;
        winner_id_d    = winner_id_q;
        winner_valid_d = 1'b0;
        tie_d          = 1'b0;
        false_start_d  = 1'b0;
        any_win        = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (score_q[p] == WIN_C) any_win = 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                    for (int p = 0; p < NUM_PLAYERS; p++) score_d[p] = '0;
                end
            end
            ST_ARM: begin
                if (bus.btn == '0) begin
                    cnt_d   = MIN_C + CNT_W'(bus.rand_in);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (press != '0) begin
                    false_start_d = 1'b1;
                    state_d       = ST_ARM;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (press[p] && score_q[p] != '0) score_d[p] = score_q[p] - SCORE_W'(1);
                    end
                end else if (bus.tick) begin
                    if (cnt_q == '0) begin
                        state_d = ST_GO;
                        cnt_d   = TIMEOUT_C;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_GO: begin
                // A press always beats a timeout landing on the same tick.
                if (one_hot) begin
                    winner_valid_d = 1'b1;
                    winner_id_d    = press_id;
                    state_d        = ST_RESULT;
                    cnt_d          = HOLD_C;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (press[p] && score_q[p] < WIN_C) score_d[p] = score_q[p] + SCORE_W'(1);
                    end
                end else if (multi) begin
                    tie_d   = 1'b1;
                    state_d = ST_RESULT;
                    cnt_d   = HOLD_C;
                end else if (bus.tick) begin
                    if (cnt_q == '0) begin
                        state_d = ST_RESULT;
                        cnt_d   = HOLD_C;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_RESULT: begin
                if (bus.tick) begin
                    if (cnt_q == '0) begin
                        state_d = any_win ? ST_OVER : ST_ARM;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        leds_on_d    = (state_d == ST_GO);
        match_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
            leds_on_q      <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
            tie_q          <= 1'b0;
            false_start_q  <= 1'b0;
            match_over_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_q        <= score_d;
            leds_on_q      <= leds_on_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
            tie_q          <= tie_d;
            false_start_q  <= false_start_d;
            match_over_q   <= match_over_d;
        end
    end

    assign bus.leds_on      = leds_on_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.winner_id    = winner_id_q;
    assign bus.tie          = tie_q;
    assign bus.false_start  = false_start_q;
    assign bus.match_over   = match_over_q;
    assign bus.state_o      = state_q;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
        assign bus.scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Directed bench for tow_round_ctrl with four players and short timeout/hold.
// Expected values are hand-derived constants for each step of the match.
module tb_tow_round_ctrl;

    localparam int NP = 4;
    localparam int SW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    tow_round_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .DELAY_W(DW)) bus ();

    tow_round_ctrl #(
        .NUM_PLAYERS   (NP),
        .SCORE_W       (SW),
        .DELAY_W       (DW),
        .MIN_DELAY     (16),
        .TIMEOUT_TICKS (3),
        .HOLD_TICKS    (4),
        .WIN_SCORE     (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
    endtask

    // ARM -> WAIT (delay 16+4=20 loaded) -> 21st tick enters GO.
    task automatic go_round();
        step();
        ticks(21);
    endtask

    // HOLD=4: four ticks count down, the fifth leaves RESULT.
    task automatic finish_result();
        ticks(5);
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.rand_in = 8'd4;
        bus.btn     = '0;
        bus.start   = 1'b0;
        step();
        step();
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_scores", 32'(bus.scores), 32'd0);
        chk("rst_leds", 32'(bus.leds_on), 32'd0);
        rst = 1'b1;

        // Round 1: clean win by player 1
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_arm", 32'(bus.state_o), 32'd1);
        step();
        chk("enter_wait", 32'(bus.state_o), 32'd2);
        ticks(20);
        chk("wait_20_state", 32'(bus.state_o), 32'd2);
        chk("wait_20_leds", 32'(bus.leds_on), 32'd0);
        ticks(1);
        chk("go_state", 32'(bus.state_o), 32'd3);
        chk("go_leds", 32'(bus.leds_on), 32'd1);
        bus.btn = 4'b0010;
        step();
        chk("win1_valid", 32'(bus.winner_valid), 32'd1);
        chk("win1_id", 32'(bus.winner_id), 32'd1);
        chk("win1_scores", 32'(bus.scores), 32'h0000_0100);
        chk("win1_result", 32'(bus.state_o), 32'd4);
        step();
        chk("win1_pulse_end", 32'(bus.winner_valid), 32'd0);
        bus.btn = '0;
        finish_result();
        chk("result_to_arm", 32'(bus.state_o), 32'd1);

        // Round 2: false start by p0 (saturates) and p1 (1 -> 0), held buttons keep ARM
        step();
        chk("wait2", 32'(bus.state_o), 32'd2);
        bus.btn = 4'b0011;
        step();
        chk("fs_pulse", 32'(bus.false_start), 32'd1);
        chk("fs_state", 32'(bus.state_o), 32'd1);
        chk("fs_scores", 32'(bus.scores), 32'd0);
        step();
        chk("fs_pulse_end", 32'(bus.false_start), 32'd0);
        step();
        chk("fs_held_arm", 32'(bus.state_o), 32'd1);
        bus.btn = '0;
        step();
        chk("fs_release_wait", 32'(bus.state_o), 32'd2);

        // start outside IDLE/OVER is ignored
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_ignored", 32'(bus.state_o), 32'd2);

        // Round 3: tie between p0 and p2
        ticks(21);
        chk("go3", 32'(bus.state_o), 32'd3);
        bus.btn = 4'b0101;
        step();
        bus.btn = '0;
        chk("tie_pulse", 32'(bus.tie), 32'd1);
        chk("tie_state", 32'(bus.state_o), 32'd4);
        chk("tie_no_win", 32'(bus.winner_valid), 32'd0);
        chk("tie_scores", 32'(bus.scores), 32'd0);
        finish_result();

        // Round 4: timeout void, then press on the timeout tick wins
        go_round();
        ticks(3);
        chk("to_still_go", 32'(bus.state_o), 32'd3);
        ticks(1);
        chk("to_result", 32'(bus.state_o), 32'd4);
        chk("to_no_win", 32'(bus.winner_valid), 32'd0);
        chk("to_no_tie", 32'(bus.tie), 32'd0);
        chk("to_leds_off", 32'(bus.leds_on), 32'd0);
        finish_result();
        go_round();
        ticks(3);
        bus.btn  = 4'b0100;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.btn  = '0;
        chk("to_press_valid", 32'(bus.winner_valid), 32'd1);
        chk("to_press_id", 32'(bus.winner_id), 32'd2);
        chk("to_press_scores", 32'(bus.scores), 32'h0001_0000);
        finish_result();
        chk("to_press_arm", 32'(bus.state_o), 32'd1);

        // Match: p1 wins seven rounds
        for (int i = 1; i <= 7; i++) begin
            go_round();
            bus.btn = 4'b0010;
            step();
            bus.btn = '0;
            chk("p1_score", 32'(bus.scores[SW +: SW]), 32'(i));
            finish_result();
            chk("p1_next_state", 32'(bus.state_o), (i == 7) ? 32'd5 : 32'd1);
        end
        chk("over_flag", 32'(bus.match_over), 32'd1);
        chk("over_scores", 32'(bus.scores), 32'h0001_0700);
        bus.btn = 4'b0001;
        step();
        bus.btn = '0;
        step();
        chk("over_frozen_state", 32'(bus.state_o), 32'd5);
        chk("over_frozen_scores", 32'(bus.scores), 32'h0001_0700);
        chk("over_no_win", 32'(bus.winner_valid), 32'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart_state", 32'(bus.state_o), 32'd1);
        chk("restart_scores", 32'(bus.scores), 32'd0);
        chk("restart_over", 32'(bus.match_over), 32'd0);

        // Reset in GO with a nonzero score; a glitch between edges does nothing
        go_round();
        bus.btn = 4'b0001;
        step();
        bus.btn = '0;
        chk("pre_rst_scores", 32'(bus.scores), 32'd1);
        finish_result();
        go_round();
        chk("pre_rst_go", 32'(bus.state_o), 32'd3);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        chk("glitch_state", 32'(bus.state_o), 32'd3);
        chk("glitch_leds", 32'(bus.leds_on), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_state", 32'(bus.state_o), 32'd0);
        chk("mid_rst_leds", 32'(bus.leds_on), 32'd0);
        chk("mid_rst_scores", 32'(bus.scores), 32'd0);
        chk("mid_rst_id", 32'(bus.winner_id), 32'd0);
        chk("mid_rst_over", 32'(bus.match_over), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
